// File: rtl/term_pkg.sv
// term_pkg: shared constants, state encoding and byte classification for
// the text-terminal write controller.
//   ASCII_*     control / printable boundary codes
//   ST_*        state encoding of the controller FSM
//   state_e     FSM state type built on the ST_* codes
//   byte_cls_e  class of a received byte (printable, newline, backspace, other)
//   classify()  maps a received byte onto byte_cls_e
package term_pkg;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_SP    = 8'h20;
  localparam logic [7:0] ASCII_TILDE = 8'h7E;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PUT   = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;
  localparam logic [1:0] ST_ECHO  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    PUT   = ST_PUT,
    CLEAR = ST_CLEAR,
    ECHO  = ST_ECHO
  } state_e;

  typedef enum logic [1:0] {
    CLS_PRINT,
    CLS_NEWLINE,
    CLS_BACK,
    CLS_OTHER
  } byte_cls_e;

  // CR and LF behave identically on this display: both start a new line.
  function automatic byte_cls_e classify(input logic [7:0] b);
    if (b >= ASCII_SP && b <= ASCII_TILDE) return CLS_PRINT;
    if (b == ASCII_CR || b == ASCII_LF)    return CLS_NEWLINE;
    if (b == ASCII_BS)                     return CLS_BACK;
    return CLS_OTHER;
  endfunction

endpackage

// File: rtl/term_cursor.sv
// term_cursor: cursor position registers with the screen wrap rules.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   i_inc             advance one cell (col+1, wrapping into the next row)
//   i_newline         go to column 0 of the next row
//   i_back            step back one cell, sticking at (0,0)
//   i_home            go to (0,0)
//   o_row, o_col      registered cursor position
//   o_back_row/col    combinational preview of the position i_back would give
// Commands are one-hot; if several are raised anyway, home > inc > newline > back.
module term_cursor
  import term_pkg::*;
#(
  parameter int COLS  = 32,
  parameter int ROWS  = 4,
  parameter int COL_W = 5,
  parameter int ROW_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_newline,
  input  logic             i_back,
  input  logic             i_home,
  output logic [ROW_W-1:0] o_row,
  output logic [COL_W-1:0] o_col,
  output logic [ROW_W-1:0] o_back_row,
  output logic [COL_W-1:0] o_back_col
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] w_row_next;
  logic [ROW_W-1:0] w_back_row;
  logic [COL_W-1:0] w_back_col;

  // Next row with wrap from the bottom line back to the top.
  assign w_row_next = (r_row == LAST_ROW) ? '0 : r_row + ROW_W'(1);

  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latch.
    w_back_row = r_row;
    w_back_col = r_col;
    if (r_col != '0) begin
      w_back_col = r_col - COL_W'(1);
    end else if (r_row != '0) begin
      w_back_row = r_row - ROW_W'(1);
      w_back_col = LAST_COL;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignments for all state so every register samples
    // pre-edge values regardless of statement order.
    if (!reset) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_home) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_inc) begin
      if (r_col == LAST_COL) begin
        r_col <= '0;
        r_row <= w_row_next;
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end else if (i_newline) begin
      r_col <= '0;
      r_row <= w_row_next;
    end else if (i_back) begin
      r_row <= w_back_row;
      r_col <= w_back_col;
    end
  end

  assign o_row      = r_row;
  assign o_col      = r_col;
  assign o_back_row = w_back_row;
  assign o_back_col = w_back_col;

endmodule

// File: rtl/term_write_ctrl.sv
// term_write_ctrl: owns the write port of the character-cell RAM behind the
// text display. Turns received bytes into cell writes and cursor moves and
// runs the full-screen clear sweep.
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   rx_valid, rx_data           one-cycle strobe with the received byte
//   clr_req                     one-cycle clear-screen strobe
//   wr_en/wr_row/wr_col/wr_data RAM write port (registered)
//   cur_row, cur_col            cursor position
//   busy                        high whenever the FSM is not IDLE
//   ovr                         sticky: a received byte was dropped
//   tx_start, tx_data, tx_busy  echo handshake to the UART transmitter
// Build option: define ECHO_EN to echo every accepted byte through the
// transmitter; without it tx_start/tx_data are tied to 0 and tx_busy is unused.
module term_write_ctrl
  import term_pkg::*;
#(
  parameter int COLS  = 32,
  parameter int ROWS  = 4,
  parameter int COL_W = 5,
  parameter int ROW_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             clr_req,
  output logic             wr_en,
  output logic [ROW_W-1:0] wr_row,
  output logic [COL_W-1:0] wr_col,
  output logic [7:0]       wr_data,
  output logic [ROW_W-1:0] cur_row,
  output logic [COL_W-1:0] cur_col,
  output logic             busy,
  output logic             ovr,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  input  logic             tx_busy
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  state_e           r_state, w_nxt_state;
  logic [7:0]       r_byte, w_nxt_byte;
  logic             r_wr_en, w_nxt_wr_en;
  logic [ROW_W-1:0] r_wr_row, w_nxt_wr_row;
  logic [COL_W-1:0] r_wr_col, w_nxt_wr_col;
  logic [7:0]       r_wr_data, w_nxt_wr_data;
  logic             r_busy;
  logic             r_ovr, w_nxt_ovr;

  logic             w_cmd_inc, w_cmd_newline, w_cmd_back, w_cmd_home;
  logic [ROW_W-1:0] w_cur_row, w_back_row;
  logic [COL_W-1:0] w_cur_col, w_back_col;
  byte_cls_e        w_rx_cls, w_put_cls;

`ifdef ECHO_EN
  logic             r_tx_start, w_nxt_tx_start;
  logic [7:0]       r_tx_data, w_nxt_tx_data;
`endif

  term_cursor #(
    .COLS  (COLS),
    .ROWS  (ROWS),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_cursor (
    .clk        (clk),
    .reset      (reset),
    .i_inc      (w_cmd_inc),
    .i_newline  (w_cmd_newline),
    .i_back     (w_cmd_back),
    .i_home     (w_cmd_home),
    .o_row      (w_cur_row),
    .o_col      (w_cur_col),
    .o_back_row (w_back_row),
    .o_back_col (w_back_col)
  );

  assign w_rx_cls  = classify(rx_data);
  assign w_put_cls = classify(r_byte);

  // Next-state / next-output logic. The write for a received byte is decided
  // on the accepting edge so it appears in the PUT cycle; the cursor moves on
  // the PUT edge, which is why a backspace write uses the back-step preview.
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_byte    = r_byte;
    w_nxt_wr_en   = 1'b0;
    w_nxt_wr_row  = r_wr_row;
    w_nxt_wr_col  = r_wr_col;
    w_nxt_wr_data = r_wr_data;
    w_nxt_ovr     = r_ovr;
    w_cmd_inc     = 1'b0;
    w_cmd_newline = 1'b0;
    w_cmd_back    = 1'b0;
    w_cmd_home    = 1'b0;
`ifdef ECHO_EN
    w_nxt_tx_start = 1'b0;
    w_nxt_tx_data  = r_tx_data;
`endif

    case (r_state)
      IDLE: begin
        if (clr_req) begin
          // The write address registers double as the sweep counter.
          w_nxt_state   = CLEAR;
          w_nxt_ovr     = 1'b0;
          w_nxt_wr_en   = 1'b1;
          w_nxt_wr_row  = '0;
          w_nxt_wr_col  = '0;
          w_nxt_wr_data = ASCII_SP;
        end else if (rx_valid) begin
          w_nxt_byte  = rx_data;
          w_nxt_state = PUT;
          case (w_rx_cls)
            CLS_PRINT: begin
              w_nxt_wr_en   = 1'b1;
              w_nxt_wr_row  = w_cur_row;
              w_nxt_wr_col  = w_cur_col;
              w_nxt_wr_data = rx_data;
            end
            CLS_BACK: begin
              w_nxt_wr_en   = 1'b1;
              w_nxt_wr_row  = w_back_row;
              w_nxt_wr_col  = w_back_col;
              w_nxt_wr_data = ASCII_SP;
            end
            default: ;
          endcase
        end
      end

      PUT: begin
        w_cmd_inc     = (w_put_cls == CLS_PRINT);
        w_cmd_newline = (w_put_cls == CLS_NEWLINE);
        w_cmd_back    = (w_put_cls == CLS_BACK);
`ifdef ECHO_EN
        w_nxt_state   = ECHO;
`else
        w_nxt_state   = IDLE;
`endif
      end

      CLEAR: begin
        if (r_wr_row == LAST_ROW && r_wr_col == LAST_COL) begin
          w_nxt_state = IDLE;
          w_nxt_ovr   = 1'b0;
          w_cmd_home  = 1'b1;
        end else begin
          w_nxt_wr_en = 1'b1;
          if (r_wr_col == LAST_COL) begin
            w_nxt_wr_col = '0;
            w_nxt_wr_row = r_wr_row + ROW_W'(1);
          end else begin
            w_nxt_wr_col = r_wr_col + COL_W'(1);
          end
        end
      end

`ifdef ECHO_EN
      ECHO: begin
        if (!tx_busy) begin
          w_nxt_tx_start = 1'b1;
          w_nxt_tx_data  = r_byte;
          w_nxt_state    = IDLE;
        end
      end
`endif

      default: w_nxt_state = IDLE;
    endcase

    // Any byte that cannot be taken is reported; this wins over the clears
    // above so a drop on the same edge is never lost.
    if (rx_valid && (r_state != IDLE || clr_req)) begin
      w_nxt_ovr = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_byte    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_row  <= '0;
      r_wr_col  <= '0;
      r_wr_data <= '0;
      r_busy    <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_byte    <= w_nxt_byte;
      r_wr_en   <= w_nxt_wr_en;
      r_wr_row  <= w_nxt_wr_row;
      r_wr_col  <= w_nxt_wr_col;
      r_wr_data <= w_nxt_wr_data;
      r_busy    <= (w_nxt_state != IDLE);
      r_ovr     <= w_nxt_ovr;
    end
  end

`ifdef ECHO_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_tx_start <= w_nxt_tx_start;
      r_tx_data  <= w_nxt_tx_data;
    end
  end

  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
`else
  logic w_unused_tx_busy;
  assign w_unused_tx_busy = tx_busy;
  assign tx_start = 1'b0;
  assign tx_data  = '0;
`endif

  assign wr_en   = r_wr_en;
  assign wr_row  = r_wr_row;
  assign wr_col  = r_wr_col;
  assign wr_data = r_wr_data;
  assign cur_row = w_cur_row;
  assign cur_col = w_cur_col;
  assign busy    = r_busy;
  assign ovr     = r_ovr;

endmodule

// File: tb/tb_term_write_ctrl.sv
// tb_term_write_ctrl: self-checking bench for term_write_ctrl.
// Cursor is modelled as a linear cell index (row*COLS+col) with modular
// arithmetic; writes, cursor and the overrun flag are compared against it.
module tb_term_write_ctrl;

  localparam int COLS  = 32;
  localparam int ROWS  = 4;
  localparam int CELLS = COLS * ROWS;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       clr_req = 1'b0;
  logic       tx_busy = 1'b0;
  logic       wr_en;
  logic [1:0] wr_row;
  logic [4:0] wr_col;
  logic [7:0] wr_data;
  logic [1:0] cur_row;
  logic [4:0] cur_col;
  logic       busy;
  logic       ovr;
  logic       tx_start;
  logic [7:0] tx_data;

  always #5 clk = ~clk;

  term_write_ctrl #(.COLS(COLS), .ROWS(ROWS), .COL_W(5), .ROW_W(2)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .clr_req(clr_req), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_data(wr_data), .cur_row(cur_row), .cur_col(cur_col), .busy(busy),
    .ovr(ovr), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Echo monitor: counts tx_start cycles and remembers the last byte sent.
  int         tx_cnt = 0;
  logic [7:0] tx_last = 8'h00;
  always @(negedge clk) begin
    if (tx_start) begin
      tx_cnt++;
      tx_last = tx_data;
    end
  end

  // Reference model state.
  int m_pos = 0;
  bit m_ovr = 0;

  function automatic void model_expect(input logic [7:0] b, input int pos, output bit we,
                                       output int waddr, output logic [7:0] wd, output int npos);
    we = 0; waddr = 0; wd = 8'h20; npos = pos;
    if (b >= 8'h20 && b <= 8'h7E) begin
      we = 1; waddr = pos; wd = b; npos = (pos + 1) % CELLS;
    end else if (b == 8'h0D || b == 8'h0A) begin
      npos = ((pos / COLS + 1) % ROWS) * COLS;
    end else if (b == 8'h08) begin
      npos = (pos > 0) ? pos - 1 : 0;
      we = 1; waddr = npos;
    end
  endfunction

  function automatic int cur_idx();
    return int'(cur_row) * COLS + int'(cur_col);
  endfunction

  // Observations of one byte transfer.
  logic       o_we, o_we2, o_ovr, o_idle_ok;
  int         o_waddr, o_mid, o_fin;
  logic [7:0] o_wd;

  // Strobe a byte in cycle N, sample write port in N+1 and cursor in N+2.
  task automatic xfer(input logic [7:0] b, input bit overlap);
    @(negedge clk); rx_valid = 1'b1; rx_data = b;
    @(negedge clk);
    o_we = wr_en; o_waddr = int'(wr_row) * COLS + int'(wr_col); o_wd = wr_data;
    o_mid = cur_idx();
    rx_valid = overlap; rx_data = 8'hEE;
    @(negedge clk); rx_valid = 1'b0;
    o_fin = cur_idx(); o_we2 = wr_en; o_ovr = ovr;
    o_idle_ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) begin o_idle_ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic step(input logic [7:0] b, input bit overlap, input string tag);
    bit we; int waddr; logic [7:0] wd; int npos; int tx_before;
    model_expect(b, m_pos, we, waddr, wd, npos);
    tx_before = tx_cnt;
    xfer(b, overlap);
    if (overlap) m_ovr = 1;
    check({tag, " wr_en"}, o_we, we);
    if (we) begin
      check({tag, " wr_addr"}, o_waddr, waddr);
      check({tag, " wr_data"}, o_wd, wd);
    end
    check({tag, " cursor_n1"}, o_mid, m_pos);
    check({tag, " cursor_n2"}, o_fin, npos);
    check({tag, " wr_en_n2"}, o_we2, 0);
    check({tag, " ovr"}, o_ovr, m_ovr);
    check({tag, " idle"}, o_idle_ok, 1);
`ifdef ECHO_EN
    check({tag, " echo_cnt"}, tx_cnt, tx_before + 1);
    check({tag, " echo_data"}, tx_last, b);
`else
    check({tag, " no_echo"}, tx_cnt, tx_before);
`endif
    m_pos = npos;
  endtask

  task automatic do_clear(input bit with_rx, input bit inject, input string tag);
    int cnt; bit order_ok; bit data_ok; bit done; logic ovr_mid;
    @(negedge clk); clr_req = 1'b1; rx_valid = with_rx; rx_data = 8'h55;
    @(negedge clk); clr_req = 1'b0; rx_valid = 1'b0;
    check({tag, " ovr_at_accept"}, ovr, with_rx);
    cnt = 0; order_ok = 1; data_ok = 1; done = 0; ovr_mid = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (!busy) begin done = 1; break; end
      if (wr_en) begin
        if (cnt != int'(wr_row) * COLS + int'(wr_col)) order_ok = 0;
        if (wr_data != 8'h20) data_ok = 0;
        cnt++;
      end else begin
        order_ok = 0;
      end
      if (inject && cyc == 50) begin rx_valid = 1'b1; rx_data = 8'h66; clr_req = 1'b1; end
      if (inject && cyc == 51) begin rx_valid = 1'b0; clr_req = 1'b0; end
      if (cyc == 53) ovr_mid = ovr;
      @(negedge clk);
    end
    check({tag, " sweep_done"}, done, 1);
    check({tag, " write_count"}, cnt, CELLS);
    check({tag, " row_major_order"}, order_ok, 1);
    check({tag, " data_space"}, data_ok, 1);
    if (inject) check({tag, " ovr_mid_sweep"}, ovr_mid, 1);
    check({tag, " cursor_home"}, cur_idx(), 0);
    check({tag, " ovr_after"}, ovr, 0);
    check({tag, " wr_en_after"}, wr_en, 0);
    m_pos = 0; m_ovr = 0;
  endtask

  typedef struct {
    logic [7:0] rx;
    logic       we;
    int         wrow;
    int         wcol;
    logic [7:0] wd;
    int         crow;
    int         ccol;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{8'h41, 1'b1, 0, 0,  8'h41, 0, 1};
    vecs[1]  = '{8'h7E, 1'b1, 0, 1,  8'h7E, 0, 2};
    vecs[2]  = '{8'h0D, 1'b0, 0, 0,  8'h00, 1, 0};
    vecs[3]  = '{8'h20, 1'b1, 1, 0,  8'h20, 1, 1};
    vecs[4]  = '{8'h1F, 1'b0, 0, 0,  8'h00, 1, 1};
    vecs[5]  = '{8'h7F, 1'b0, 0, 0,  8'h00, 1, 1};
    vecs[6]  = '{8'h08, 1'b1, 1, 0,  8'h20, 1, 0};
    vecs[7]  = '{8'h08, 1'b1, 0, 31, 8'h20, 0, 31};
    vecs[8]  = '{8'h42, 1'b1, 0, 31, 8'h42, 1, 0};
    vecs[9]  = '{8'h0A, 1'b0, 0, 0,  8'h00, 2, 0};
    vecs[10] = '{8'h08, 1'b1, 1, 31, 8'h20, 1, 31};
    vecs[11] = '{8'h0A, 1'b0, 0, 0,  8'h00, 2, 0};

    // Reset state.
    #12;
    check("rst wr_en", wr_en, 0);
    check("rst wr_addr", {wr_row, wr_col}, 0);
    check("rst wr_data", wr_data, 0);
    check("rst cursor", {cur_row, cur_col}, 0);
    check("rst busy", busy, 0);
    check("rst ovr", ovr, 0);
    check("rst tx", {tx_start, tx_data}, 0);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst busy", busy, 0);

    // Table-driven byte classes from (0,0).
    foreach (vecs[i]) begin
      xfer(vecs[i].rx, 1'b0);
      check($sformatf("vec%0d wr_en", i), o_we, vecs[i].we);
      if (vecs[i].we) begin
        check($sformatf("vec%0d wr_addr", i), o_waddr, vecs[i].wrow * COLS + vecs[i].wcol);
        check($sformatf("vec%0d wr_data", i), o_wd, vecs[i].wd);
      end
      check($sformatf("vec%0d cursor", i), o_fin, vecs[i].crow * COLS + vecs[i].ccol);
      check($sformatf("vec%0d cursor_n1", i), o_mid, m_pos);
      m_pos = vecs[i].crow * COLS + vecs[i].ccol;
    end

    // Bottom-right wrap: reach (3,31), then a printable wraps to (0,0).
    step(8'h0A, 0, "to_row3");
    for (int i = 0; i < 31; i++) step(8'h78, 0, "fill_row3");
    check("at_3_31", cur_idx(), 3 * COLS + 31);
    step(8'h43, 0, "wrap_end");
    check("wrap_to_origin", cur_idx(), 0);

    // From (2,5): CR, then backspace across a row boundary.
    step(8'h0A, 0, "nl1");
    step(8'h0A, 0, "nl2");
    for (int i = 0; i < 5; i++) step(8'h79, 0, "to_2_5");
    check("at_2_5", cur_idx(), 2 * COLS + 5);
    step(8'h0D, 0, "cr_2_5");
    check("cr_to_3_0", cur_idx(), 3 * COLS);
    step(8'h08, 0, "bs_3_0");
    check("bs_to_2_31", cur_idx(), 2 * COLS + 31);

    // Plain clear, then backspace at the origin.
    do_clear(0, 0, "clr1");
    step(8'h08, 0, "bs_origin");
    check("bs_origin_stays", cur_idx(), 0);

    // Drop while busy sets ovr; next clear clears it; drops mid-sweep.
    step(8'h61, 1, "drop_in_put");
    do_clear(0, 1, "clr2");

    // Clear and byte in the same cycle: clear wins, byte dropped.
    do_clear(1, 0, "clr_rx_same");

    // Randomised bytes against the model.
    for (int i = 0; i < 300; i++) begin
      int cls; logic [7:0] b; bit ov;
      cls = $urandom_range(0, 9);
      if (cls < 5)       b = 8'($urandom_range(32, 126));
      else if (cls == 5) b = 8'h0D;
      else if (cls == 6) b = 8'h0A;
      else if (cls < 9)  b = 8'h08;
      else               b = 8'($urandom_range(0, 255));
      ov = ($urandom_range(0, 4) == 0);
      step(b, ov, $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

`ifdef ECHO_EN
    begin
      int tb0; bit idle_ok;
      tb0 = tx_cnt;
      tx_busy = 1'b1;
      @(negedge clk); rx_valid = 1'b1; rx_data = 8'h5A;
      @(negedge clk); rx_valid = 1'b0;
      repeat (3) @(negedge clk);
      rx_valid = 1'b1; rx_data = 8'h11;
      @(negedge clk); rx_valid = 1'b0;
      repeat (6) @(negedge clk);
      check("echo wait busy", busy, 1);
      check("echo held off", tx_cnt, tb0);
      check("echo drop ovr", ovr, 1);
      tx_busy = 1'b0;
      idle_ok = 0;
      for (int i = 0; i < 20; i++) begin
        if (!busy) begin idle_ok = 1; break; end
        @(negedge clk);
      end
      @(negedge clk);
      check("echo idle", idle_ok, 1);
      check("echo pulse count", tx_cnt, tb0 + 1);
      check("echo data", tx_last, 8'h5A);
      m_pos = (m_pos + 1) % CELLS; m_ovr = 1;
      check("echo cursor", cur_idx(), m_pos);
    end
`endif

    // Reset in the middle of a sweep.
    step(8'h62, 0, "pre_rst");
    @(negedge clk); clr_req = 1'b1;
    @(negedge clk); clr_req = 1'b0;
    repeat (5) @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h33;
    @(negedge clk); rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_sweep busy", busy, 1);
    check("mid_sweep wr_en", wr_en, 1);
    check("mid_sweep ovr", ovr, 1);
    #2 reset = 1'b0;
    #1;
    check("async_rst wr_en", wr_en, 0);
    check("async_rst busy", busy, 0);
    check("async_rst ovr", ovr, 0);
    check("async_rst cursor", {cur_row, cur_col}, 0);
    check("async_rst wr_addr", {wr_row, wr_col}, 0);
    @(negedge clk); reset = 1'b1;
    begin
      bit quiet = 1;
      repeat (5) begin
        @(negedge clk);
        if (busy || wr_en) quiet = 0;
      end
      check("no_sweep_resume", quiet, 1);
    end
    m_pos = 0; m_ovr = 0;
    step(8'h63, 0, "after_rst");

`ifndef ECHO_EN
    check("tx_never_started", tx_cnt, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/term_write_ctrl.md
Name: term_write_ctrl

Overview:
- Sequencer that owns the write port of the character-cell RAM behind the VGA text display.
- Accepts decoded UART receive bytes and a clear-screen request, and tracks the cursor.
- Converts printable, CR/LF and backspace codes into RAM writes and cursor moves; runs a full-screen clear sweep.
- Sits between the UART receiver / button pulsers and the dual-port RAM write side; cursor outputs feed the 7-segment status display.

Parameters:
- COLS, 32, characters per row
- ROWS, 4, rows on screen
- COL_W, 5, column index width, equals $clog2(COLS)
- ROW_W, 2, row index width, equals $clog2(ROWS)

Ports:
- clk  in  1  100 MHz system clock
- reset  in  1  asynchronous, active-low reset
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
- rx_data  in  8  received byte
- clr_req  in  1  one-cycle clear-screen strobe
- wr_en  out  1  RAM write enable
- wr_row  out  ROW_W  RAM write row
- wr_col  out  COL_W  RAM write column
- wr_data  out  8  RAM write data
- cur_row  out  ROW_W  current cursor row
- cur_col  out  COL_W  current cursor column
- busy  out  1  high in any state other than IDLE
- ovr  out  1  sticky flag: a byte was dropped
- tx_start  out  1  echo transmit strobe (ECHO_EN only)
- tx_data  out  8  echo byte (ECHO_EN only)
- tx_busy  in  1  UART transmitter busy

Behaviour:
- Reset (reset=0, async): state IDLE, cursor (0,0), ovr=0. All other outputs are 0.
- All outputs are registered.
- States: IDLE, PUT, CLEAR, ECHO.
- IDLE, clr_req=1: go to CLEAR, clear-sweep counter = 0. If rx_valid is also high that cycle, the byte is dropped and ovr is set (clear wins).
- IDLE, rx_valid=1 (accepted in cycle N): latch the byte and go to PUT; the cycle N+1 action depends on the byte class.
  - Printable (0x20..0x7E): wr_en=1 with wr_row/wr_col = old cursor and wr_data = byte. Cursor then advances.
  - Cursor advance: col+1; at col=COLS-1 it goes to col 0, row+1; row wraps ROWS-1 to 0.
  - CR (0x0D) or LF (0x0A): no write. Cursor goes to col 0, row+1 with row wrap.
  - BS (0x08): cursor steps back. If col>0, col-1. Else if row>0, row-1 and col=COLS-1. Else the cursor stays at (0,0).
  - BS then writes 0x20 at the new position in the same cycle N+1 (wr_en=1).
  - Any other code: no write, no cursor change.
  - New cursor is visible on cur_row/cur_col from cycle N+2.
  - PUT lasts one cycle, then goes to ECHO (ECHO_EN) or IDLE.
- rx_valid while busy=1: byte dropped, ovr set.
- ovr clears only when a clr_req is accepted.
- CLEAR: one write per cycle, wr_data=0x20, row-major from (0,0) to (ROWS-1,COLS-1): exactly ROWS*COLS cycles with wr_en=1.
  - Then cursor becomes (0,0), ovr=0, state IDLE.
  - clr_req during CLEAR is ignored; the sweep does not restart.
- reset asserted mid-sweep or mid-PUT: immediate return to reset values; no partial-write completion.
- wr_en is 0 in IDLE and ECHO.

Optional Feature:
- Macro ECHO_EN.
- Defined:
  - After PUT, enter ECHO and wait for tx_busy=0.
  - Then pulse tx_start for one cycle with tx_data = latched byte, and return to IDLE.
  - CR is echoed as the single byte 0x0D.
  - The ECHO state, tx_start and tx_data logic are all present.
- Undefined:
  - The ECHO state is omitted; PUT returns straight to IDLE.
  - tx_start and tx_data are tied to 0; tx_busy is unused.

Decomposition:
- Package term_pkg holds:
  - constants ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_BS=8'h08, ASCII_SP=8'h20, ASCII_TILDE=8'h7E
  - state encoding localparams for IDLE/PUT/CLEAR/ECHO
- Sub-module term_cursor holds the cursor registers. It takes one-hot commands inc, newline, back and home, handles the wrap rules, and shares clk/reset.

Test Plan:
- Reset, then rx 0x41 at (0,0) -> one-cycle wr_en with (0,0,0x41); cursor becomes (0,1) two cycles after the strobe.
- Drive cursor to (0,31) and send 0x42 -> write at (0,31); cursor (1,0). At (3,31), send 0x43 -> cursor (0,0).
- From (2,5): send 0x0D -> no wr_en, cursor (3,0). Then 0x08 -> cursor (2,31) and write 0x20 there. At (0,0), 0x08 -> write 0x20 at (0,0), cursor stays.
- clr_req -> exactly 128 consecutive wr_en cycles covering all 128 cells with 0x20. Then cursor (0,0), busy=0. An rx_valid mid-sweep sets ovr; the next clr_req clears it.
- clr_req and rx_valid in the same IDLE cycle -> clear sweep runs, byte not written, ovr=1.
- ECHO_EN with tx_busy held high 10 cycles after rx 0x5A -> tx_start pulses once after tx_busy falls, tx_data=0x5A. Another rx during the wait -> dropped, ovr=1.
